// File: rtl/ring_pkg.sv
// Shared types and helpers for ring-counter consumers: FSM state enum,
// ring reset pattern and a width-generic rotate-left.
package ring_pkg;

   localparam int unsigned RING_MAX_W = 64;

   // Ring reset pattern: only bit 0 set; consumers truncate to their width.
   localparam logic [RING_MAX_W-1:0] RING_RST_PAT = RING_MAX_W'(1);

   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      ACQ      = 2'd1,
      LOCKED   = 2'd2
   } ring_state_e;

   // Rotate-left of the low w bits of v (v is expected to be zero above bit w-1).
   function automatic logic [RING_MAX_W-1:0] ring_rotl(input logic [RING_MAX_W-1:0] v,
                                                       input int unsigned          w);
      logic [RING_MAX_W-1:0] mask;
      mask = (RING_MAX_W'(1) << w) - RING_MAX_W'(1);
      return ((v << 1) | (v >> (w - 1))) & mask;
   endfunction

endpackage

// File: rtl/ring_decoder_if.sv
// Sample/status bundle between a ring source (master) and ring_decoder (slave).
interface ring_decoder_if #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned ERRW  = 8
);
   localparam int unsigned IDXW = $clog2(WIDTH);

   logic             en;
   logic [WIDTH-1:0] ring_in;
   logic [IDXW-1:0]  index;
   logic             onehot_ok;
   logic             locked;
   logic             seq_err;
   logic             wrap_pulse;
   logic [ERRW-1:0]  err_count;

   modport master (
      output en, ring_in,
      input  index, onehot_ok, locked, seq_err, wrap_pulse, err_count
   );

   modport slave (
      input  en, ring_in,
      output index, onehot_ok, locked, seq_err, wrap_pulse, err_count
   );

endinterface

// File: rtl/ring_onehot_enc.sv
// One-hot to binary encoder with a legality flag (exactly one bit set).
module ring_onehot_enc #(
   parameter int unsigned WIDTH = 4,
   localparam int unsigned IDXW = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] ring_i,
   output logic [IDXW-1:0]  index_c_o,
   output logic             legal_c_o
);

   always_comb begin
      index_c_o = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (ring_i[i]) index_c_o = index_c_o | IDXW'(i);
      end
      legal_c_o = (ring_i != '0) && ((ring_i & (ring_i - WIDTH'(1))) == '0);
   end

endmodule

// File: rtl/ring_decoder.sv
// Ring phase decoder and health monitor: lock acquisition, sequence checking
// and a saturating error count. Optional macro RING_DECODER_RESYNC_EN.
module ring_decoder
   import ring_pkg::*;
#(
   parameter int unsigned WIDTH  = 4,
   parameter int unsigned LOCK_N = 2,
   parameter int unsigned ERRW   = 8
) (
   input logic           clk,
   input logic           rst,
   ring_decoder_if.slave bus
);

   localparam int unsigned IDXW = $clog2(WIDTH);
   localparam int unsigned CNTW = $clog2(LOCK_N + 1);
   localparam logic [ERRW-1:0] ERR_MAX = '1;

   ring_state_e      state_q, state_d;
   logic [WIDTH-1:0] prev_q, prev_d;
   logic [CNTW-1:0]  good_cnt_q, good_cnt_d;
   logic [IDXW-1:0]  index_q, index_d;
   logic             onehot_ok_q, onehot_ok_d;
   logic             locked_q, locked_d;
   logic             seq_err_q, seq_err_d;
   logic             wrap_q, wrap_d;
   logic [ERRW-1:0]  err_cnt_q, err_cnt_d;

   logic [IDXW-1:0]  enc_idx_c;
   logic             enc_legal_c;
   logic [WIDTH-1:0] expected_c;
   logic             match_c;
   logic [CNTW-1:0]  good_inc_c;

   ring_onehot_enc #(.WIDTH(WIDTH)) u_enc (
      .ring_i    (bus.ring_in),
      .index_c_o (enc_idx_c),
      .legal_c_o (enc_legal_c)
   );

   assign expected_c = WIDTH'(ring_rotl(RING_MAX_W'(prev_q), WIDTH));
   assign match_c    = (bus.ring_in == expected_c);
   assign good_inc_c = good_cnt_q + CNTW'(1);

   // Next-state and output decode; nothing moves unless en is high.
   always_comb begin
      state_d     = state_q;
      prev_d      = prev_q;
      good_cnt_d  = good_cnt_q;
      index_d     = index_q;
      onehot_ok_d = onehot_ok_q;
      seq_err_d   = 1'b0;
      wrap_d      = 1'b0;
      err_cnt_d   = err_cnt_q;

      if (bus.en) begin
         onehot_ok_d = enc_legal_c;
         if (enc_legal_c) index_d = enc_idx_c;

         unique case (state_q)
            UNLOCKED: begin
               if (enc_legal_c) begin
                  prev_d     = bus.ring_in;
                  good_cnt_d = '0;
                  state_d    = ACQ;
               end
            end
            ACQ: begin
               if (!enc_legal_c) begin
                  state_d = UNLOCKED;
               end else if (match_c) begin
                  prev_d     = bus.ring_in;
                  good_cnt_d = good_inc_c;
                  if (good_inc_c == CNTW'(LOCK_N)) state_d = LOCKED;
               end else begin
                  prev_d     = bus.ring_in;
                  good_cnt_d = '0;
               end
            end
            LOCKED: begin
               if (match_c) begin
                  prev_d = bus.ring_in;
                  wrap_d = prev_q[WIDTH-1];
               end
`ifdef RING_DECODER_RESYNC_EN
               else if (bus.ring_in == WIDTH'(RING_RST_PAT)) begin
                  prev_d = bus.ring_in;
               end
`endif
               else begin
                  seq_err_d = 1'b1;
                  state_d   = UNLOCKED;
                  if (err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + ERRW'(1);
               end
            end
            default: state_d = UNLOCKED;
         endcase
      end

      locked_d = (state_d == LOCKED);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= UNLOCKED;
         prev_q      <= '0;
         good_cnt_q  <= '0;
         index_q     <= '0;
         onehot_ok_q <= 1'b0;
         locked_q    <= 1'b0;
         seq_err_q   <= 1'b0;
         wrap_q      <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         prev_q      <= prev_d;
         good_cnt_q  <= good_cnt_d;
         index_q     <= index_d;
         onehot_ok_q <= onehot_ok_d;
         locked_q    <= locked_d;
         seq_err_q   <= seq_err_d;
         wrap_q      <= wrap_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign bus.index      = index_q;
   assign bus.onehot_ok  = onehot_ok_q;
   assign bus.locked     = locked_q;
   assign bus.seq_err    = seq_err_q;
   assign bus.wrap_pulse = wrap_q;
   assign bus.err_count  = err_cnt_q;

endmodule

// File: tb/tb_ring_decoder.sv
// Directed bench for ring_decoder (WIDTH=4, LOCK_N=2, ERRW=8); honours
// RING_DECODER_RESYNC_EN when the build defines it.
module tb_ring_decoder;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_chk  = 0;
   int   n_fail = 0;
   int   exp_err = 0;

   always #5 clk = ~clk;

   ring_decoder_if #(.WIDTH(4), .ERRW(8)) bus ();

   ring_decoder #(.WIDTH(4), .LOCK_N(2), .ERRW(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input int idx, input bit ok, input bit lk,
                          input bit se, input bit wp, input int ec);
      chk({tag, ".index"},      32'(bus.index),      32'(idx));
      chk({tag, ".onehot_ok"},  32'(bus.onehot_ok),  32'(ok));
      chk({tag, ".locked"},     32'(bus.locked),     32'(lk));
      chk({tag, ".seq_err"},    32'(bus.seq_err),    32'(se));
      chk({tag, ".wrap_pulse"}, 32'(bus.wrap_pulse), 32'(wp));
      chk({tag, ".err_count"},  32'(bus.err_count),  32'(ec));
   endtask

   // Present one enabled sample and move to just after the capturing edge.
   task automatic step(input logic [3:0] v);
      bus.ring_in = v;
      bus.en      = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.en = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      bus.en = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.en      = 1'b0;
      bus.ring_in = 4'b0000;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk_all("reset", 0, 0, 0, 0, 0, 0);
      rst = 1'b1;

      // Clean stream with wrap
      step(4'b0001); chk_all("s1", 0, 1, 0, 0, 0, 0);
      step(4'b0010); chk_all("s2", 1, 1, 0, 0, 0, 0);
      step(4'b0100); chk_all("s3", 2, 1, 1, 0, 0, 0);
      step(4'b1000); chk_all("s4", 3, 1, 1, 0, 0, 0);
      step(4'b0001); chk_all("s5_wrap", 0, 1, 1, 0, 1, 0);
      step(4'b0010); chk_all("s6", 1, 1, 1, 0, 0, 0);

      // Multi-hot while locked
      step(4'b0110); chk_all("multihot", 1, 0, 0, 1, 0, 1);
      bus.ring_in = 4'b0100;
      idle();        chk_all("en0_hold", 1, 0, 0, 0, 0, 1);

      // Relock, then skipped step from 0010 to 1000
      step(4'b0001); step(4'b0010); step(4'b0100);
      chk("relock1.locked", 32'(bus.locked), 32'd1);
      step(4'b1000); step(4'b0001);
      chk("relock1.wrap", 32'(bus.wrap_pulse), 32'd1);
      step(4'b0010); chk_all("at_0010", 1, 1, 1, 0, 0, 1);
      step(4'b1000); chk_all("skip", 3, 1, 0, 1, 0, 2);
      step(4'b0001); chk_all("rl_a", 0, 1, 0, 0, 0, 2);
      step(4'b0010); chk_all("rl_b", 1, 1, 0, 0, 0, 2);
      step(4'b0100); chk_all("rl_c", 2, 1, 1, 0, 0, 2);

      // Reset pattern while locked at 0100
      step(4'b0001);
`ifdef RING_DECODER_RESYNC_EN
      exp_err = 2;
      chk_all("resync", 0, 1, 1, 0, 0, exp_err);
`else
      exp_err = 3;
      chk_all("resync", 0, 1, 0, 1, 0, exp_err);
`endif
      step(4'b0001); step(4'b0010); step(4'b0100);
      chk("converge.locked", 32'(bus.locked), 32'd1);
      chk("converge.err", 32'(bus.err_count), 32'(exp_err));

      // Stalled value is an error
      step(4'b0100); exp_err++;
      chk_all("stall", 2, 1, 0, 1, 0, exp_err);
      step(4'b0001); step(4'b0010); step(4'b0100);

      // Saturation: 300 error events
      for (int i = 0; i < 300; i++) begin
         step(4'b0000);
         step(4'b0001); step(4'b0010); step(4'b0100);
         if (exp_err < 255) exp_err++;
      end
      chk("sat.err", 32'(bus.err_count), 32'd255);
      chk("sat.locked", 32'(bus.locked), 32'd1);
      step(4'b0000); chk_all("sat_more", 2, 0, 0, 1, 0, 255);

      // Async reset between edges with err_count=3
      do_reset();
      chk_all("reset2", 0, 0, 0, 0, 0, 0);
      step(4'b0001); step(4'b0010); step(4'b0100);
      for (int i = 0; i < 3; i++) begin
         step(4'b0000);
         step(4'b0001); step(4'b0010); step(4'b0100);
      end
      chk_all("pre_rst", 2, 1, 1, 0, 0, 3);
      #2;
      rst = 1'b0;
      #1;
      chk_all("async_rst", 0, 0, 0, 0, 0, 0);
      bus.en = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      step(4'b0001); chk_all("post_a", 0, 1, 0, 0, 0, 0);
      step(4'b0010); chk_all("post_b", 1, 1, 0, 0, 0, 0);
      step(4'b0100); chk_all("post_c", 2, 1, 1, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ring_decoder.md
# ring_decoder

Receive-side companion to the ring counter: samples a WIDTH-bit one-hot ring pattern each enabled cycle, converts it to a binary index and checks that it advances by exactly one rotate-left per sample. It acquires lock after a run of correct steps, flags legality and sequence errors, and keeps a saturating error count. It sits downstream of any ring counter and serves as the phase decoder and health monitor for that counter.

## Interface
- WIDTH, 4, ring width in bits (≥2)
- IDXW, $clog2(WIDTH), index width (derived, not overridden)
- LOCK_N, 2, consecutive correct transitions required to lock (≥1)
- ERRW, 8, error counter width
- clk  input  1  rising-edge clock; the block's only clock
- rst  input  1  reset, asynchronous and active-low (asserted at 0)
- en  input  1  sample enable; ring_in ignored when 0
- ring_in  input  WIDTH  ring pattern under observation
- index  output  IDXW  binary position of the last legal sample
- onehot_ok  output  1  last sample had exactly one bit set
- locked  output  1  sequence lock achieved
- seq_err  output  1  one-cycle pulse: error detected while locked
- wrap_pulse  output  1  one-cycle pulse: locked step from position WIDTH-1 to position 0
- err_count  output  ERRW  saturating count of seq_err events

## Operation
- Legal sample: exactly one bit set. All-zero and multi-hot samples are illegal.
- Expected next = rotate-left of the stored previous sample: {prev[WIDTH-2:0], prev[WIDTH-1]}.
- The FSM has three states, UNLOCKED, ACQ and LOCKED, and changes only on edges where en=1.
- UNLOCKED: a legal sample stores prev, clears good_cnt and moves to ACQ. An illegal sample keeps the state in UNLOCKED.
- ACQ, sample == expected: store prev and increment good_cnt. When good_cnt reaches LOCK_N, move to LOCKED.
- ACQ, legal sample that is not expected: reload prev, clear good_cnt, stay in ACQ.
- ACQ, illegal sample: move to UNLOCKED.
- LOCKED, sample == expected: store prev and stay in LOCKED.
- LOCKED, any other sample (illegal, skipped step, or repeated value): pulse seq_err, increment err_count, move to UNLOCKED.
- A repeated (stalled) value is an error. Hold the ring with en=0 instead.
- index updates only on legal samples and holds its value across illegal samples.
- onehot_ok updates on every enabled sample.
- err_count saturates at 2^ERRW-1 and clears only on rst.
- When en=0, all state and registered outputs hold, and seq_err/wrap_pulse are 0.

## Timing
- All outputs are registered. Latency is one edge: a sample taken at edge N is reflected on the outputs after edge N.
- locked asserts after the edge that accepts the LOCK_N-th correct transition. Example: for LOCK_N=2 that is the 3rd legal sample in sequence.
- seq_err and wrap_pulse are high for exactly the one cycle after the qualifying edge.
- Reset state, applied immediately on rst=0 without waiting for a clock edge:
  - index=0, onehot_ok=0, locked=0, seq_err=0, wrap_pulse=0, err_count=0, state UNLOCKED, prev=0, good_cnt=0.
- Release of rst is taken on the next clock edge. The first enabled sample after release is treated as a sample in UNLOCKED.

## Configuration
- Macro: RING_DECODER_RESYNC_EN.
- Defined: while LOCKED, a sample equal to the ring reset pattern (bit 0 only) is accepted as a legal restart even when it is not the expected value. There is no seq_err, err_count is unchanged, locked stays 1, and prev is reloaded. wrap_pulse does not fire unless the step was a true WIDTH-1 → 0 step.
- Undefined: that sample is an ordinary sequence error.

## Structure
- Shared package ring_pkg holds:
  - the FSM state enum (UNLOCKED, ACQ, LOCKED);
  - the ring reset-pattern constant;
  - the rotate-left helper function.
- One combinational sub-module, ring_onehot_enc, takes WIDTH bits and produces IDXW bits plus a legal flag. It is reusable by other ring consumers.
- FSM, counters and output registers live in ring_decoder.

## Test plan
Setup: WIDTH=4, LOCK_N=2, en=1.
- Reset, then stream 0001,0010,0100,1000,0001 → index 0,1,2,3,0. onehot_ok=1 throughout. locked=1 after the 3rd edge. wrap_pulse once after the 5th edge. err_count=0.
- Locked, inject 0110 → onehot_ok=0, index holds 1, seq_err pulses once, err_count=1, locked=0.
- Locked at 0010, next 1000 (skipped step) → seq_err and err_count+1. Then 0001,0010,0100 → locked=1 again after the 0100 edge.
- Locked at 0100, next 0001 → with the macro: no seq_err, locked stays 1, err_count unchanged. Without it: seq_err and locked=0.
- 300 error events with ERRW=8 → err_count reads 255 and stays 255.
- Assert rst between edges while locked with err_count=3 → all outputs read 0 immediately. After release, stream 0001,0010,0100 → relock.
